// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: memory arbiter FSM states, transaction owner and
// the registered memory command bundle.
package cpu_types;

  typedef enum logic [1:0] {
    IDLE,
    INSTR,
    DATA,
    RESP
  } mem_arbiter_state_t;

  typedef enum logic {
    OWNER_INSTR,
    OWNER_DATA
  } mem_owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_cmd_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between fetch and load/store, data first with a streak guard.
// Latency: request seen in IDLE -> mem_req next cycle; mem_ack at m -> requester ack at m+1.
// Backpressure: one transaction at a time; requesters hold req until ack (fetch also until flush).
module memory_arbiter
  import cpu_types::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mask,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  mem_arbiter_state_t state_q, state_d;
  mem_owner_t         owner_q;
  mem_cmd_t           cmd_q;
  logic [SW-1:0]      streak_q;
  logic               drop_q;
  logic               mem_req_q;
  logic               instr_ack_q;
  logic               data_ack_q;
  logic [31:0]        instr_rdata_q;
  logic [31:0]        data_rdata_q;

  logic grant_data;
  logic grant_instr;
  logic mem_done;
  logic streak_sat;

  assign streak_sat = (streak_q == STREAK_MAX);

  always_comb begin
    state_d     = state_q;
    grant_data  = 1'b0;
    grant_instr = 1'b0;
    mem_done    = 1'b0;
    case (state_q)
      IDLE: begin
        // A saturated streak yields exactly one slot to a waiting fetch.
        if (data_req && !(streak_sat && instr_req)) begin
          grant_data = 1'b1;
          state_d    = DATA;
        end else if (instr_req && !flush) begin
          grant_instr = 1'b1;
          state_d     = INSTR;
        end
      end
      INSTR, DATA: begin
        if (mem_ack) begin
          mem_done = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_INSTR;
      cmd_q         <= '0;
      streak_q      <= '0;
      drop_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      instr_ack_q   <= 1'b0;
      data_ack_q    <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      instr_ack_q <= 1'b0;
      data_ack_q  <= 1'b0;

      if (grant_data) begin
        owner_q     <= OWNER_DATA;
        mem_req_q   <= 1'b1;
        cmd_q.we    <= data_we;
        cmd_q.addr  <= data_addr;
        cmd_q.wdata <= data_wdata;
        cmd_q.mask  <= data_mask;
        if (!instr_req) begin
          streak_q <= '0;
        end else if (!streak_sat) begin
          streak_q <= streak_q + 1'b1;
        end
      end

      if (grant_instr) begin
        owner_q     <= OWNER_INSTR;
        mem_req_q   <= 1'b1;
        cmd_q.we    <= 1'b0;
        cmd_q.addr  <= instr_addr;
        cmd_q.wdata <= '0;
        cmd_q.mask  <= 4'hF;
        streak_q    <= '0;
      end

      // The memory cannot abort, so a flushed fetch runs to completion silently.
      if (state_q == INSTR && flush) begin
        drop_q <= 1'b1;
      end

      if (mem_done) begin
        mem_req_q <= 1'b0;
        if (owner_q == OWNER_DATA) begin
          data_rdata_q <= mem_rdata;
          data_ack_q   <= 1'b1;
        end else begin
          instr_rdata_q <= mem_rdata;
          instr_ack_q   <= !(drop_q || flush);
        end
      end

      if (state_q == RESP) begin
        drop_q <= 1'b0;
      end
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = cmd_q.we;
  assign mem_addr    = cmd_q.addr;
  assign mem_wdata   = cmd_q.wdata;
  assign mem_mask    = cmd_q.mask;
  assign data_ack    = data_ack_q;
  assign data_rdata  = data_rdata_q;
  assign instr_rdata = instr_rdata_q;
  // A flush arriving in the response cycle must still kill the fetch ack.
  assign instr_ack   = instr_ack_q & ~flush;

endmodule
